// File: rtl/cram_read_arbiter.sv
// Two-requester arbiter for the single AXI4 read port of the code RAM, with an in-order route FIFO.
// Optional feature: define CRAM_ARB_RR_EN for round-robin arbitration (default is fixed priority, fetch first).
module cram_read_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               m0_arvalid,
    output logic                               m0_arready,
    input  logic [ADDR_W-1:0]                  m0_araddr,
    output logic                               m0_rvalid,
    input  logic                               m0_rready,
    output logic [DATA_W-1:0]                  m0_rdata,
    output logic [1:0]                         m0_rresp,
    input  logic                               m1_arvalid,
    output logic                               m1_arready,
    input  logic [ADDR_W-1:0]                  m1_araddr,
    output logic                               m1_rvalid,
    input  logic                               m1_rready,
    output logic [DATA_W-1:0]                  m1_rdata,
    output logic [1:0]                         m1_rresp,
    output logic [3:0]                         s_cram_arid,
    output logic [31:0]                        s_cram_araddr,
    output logic [7:0]                         s_cram_arlen,
    output logic [2:0]                         s_cram_arsize,
    output logic [1:0]                         s_cram_arburst,
    output logic                               s_cram_arvalid,
    input  logic                               s_cram_arready,
    input  logic [3:0]                         s_cram_rid,
    input  logic [DATA_W-1:0]                  s_cram_rdata,
    input  logic [1:0]                         s_cram_rresp,
    input  logic                               s_cram_rlast,
    input  logic                               s_cram_rvalid,
    output logic                               s_cram_rready,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               rid_err
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } lock_t;

    lock_t                      lock_state;
    lock_t                      lock_next;
    logic                       lock_sel;
    logic                       lock_sel_next;
    logic [MAX_OUTSTANDING-1:0] route;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;
    logic                       any_valid;
    logic                       grant;
    logic                       head;
    logic                       push;
    logic                       pop;
    logic                       beat_bad;
`ifdef CRAM_ARB_RR_EN
    logic                       last_grant;
`endif

    assign full      = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty     = (count == '0);
    assign any_valid = m0_arvalid | m1_arvalid;
    assign head      = route[rd_ptr];

    always_comb begin
        grant = 1'b0;
        if (lock_state == ARB_LOCKED) begin
            grant = lock_sel;
        end else if (m0_arvalid && m1_arvalid) begin
`ifdef CRAM_ARB_RR_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end else begin
            grant = m1_arvalid & ~m0_arvalid;
        end
    end

    // A presented but unaccepted request pins the grant until its handshake.
    always_comb begin
        lock_next     = ARB_OPEN;
        lock_sel_next = lock_sel;
        if (s_cram_arvalid && !s_cram_arready) begin
            lock_next     = ARB_LOCKED;
            lock_sel_next = grant;
        end
    end

    assign s_cram_arvalid = any_valid & ~full;
    assign s_cram_arid    = {3'b000, grant};
    assign s_cram_araddr  = 32'(grant ? m1_araddr : m0_araddr);
    assign s_cram_arlen   = 8'd0;
    assign s_cram_arsize  = 3'd2;
    assign s_cram_arburst = 2'd1;
    assign m0_arready     = s_cram_arready & s_cram_arvalid & ~grant;
    assign m1_arready     = s_cram_arready & s_cram_arvalid & grant;

    // A beat arriving with nothing outstanding is stalled rather than dropped.
    assign s_cram_rready = ~empty & (head ? m1_rready : m0_rready);
    assign m0_rvalid     = ~empty & ~head & s_cram_rvalid;
    assign m1_rvalid     = ~empty & head & s_cram_rvalid;
    assign m0_rdata      = s_cram_rdata;
    assign m1_rdata      = s_cram_rdata;
    assign m0_rresp      = s_cram_rresp;
    assign m1_rresp      = s_cram_rresp;

    assign push     = s_cram_arvalid & s_cram_arready;
    assign pop      = ~empty & s_cram_rvalid & s_cram_rready;
    assign beat_bad = (s_cram_rid != {3'b000, head}) | ~s_cram_rlast;

    assign outstanding = count;

    always_ff @(posedge clk) begin
        if (nrst) begin
            lock_state <= ARB_OPEN;
            lock_sel   <= 1'b0;
            route      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rid_err    <= 1'b0;
`ifdef CRAM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            lock_state <= lock_next;
            lock_sel   <= lock_sel_next;
            if (push) begin
                route[wr_ptr] <= grant;
                wr_ptr        <= wr_ptr + PTR_W'(1);
`ifdef CRAM_ARB_RR_EN
                last_grant    <= grant;
`endif
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (beat_bad) begin
                    rid_err <= 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_cram_read_arbiter.sv
// Self-checking bench for cram_read_arbiter: vector table, directed corner sequences, random run vs a queue model.
module tb_cram_read_arbiter;

`ifdef CRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic [3:0]  s_cram_arid, s_cram_rid;
    logic [31:0] s_cram_araddr, s_cram_rdata;
    logic [7:0]  s_cram_arlen;
    logic [2:0]  s_cram_arsize;
    logic [1:0]  s_cram_arburst, s_cram_rresp;
    logic        s_cram_arvalid, s_cram_arready, s_cram_rlast, s_cram_rvalid, s_cram_rready;
    logic [2:0]  outstanding;
    logic        rid_err;

    int tests_run = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    cram_read_arbiter dut (
        .clk(clk), .nrst(nrst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .s_cram_arid(s_cram_arid), .s_cram_araddr(s_cram_araddr), .s_cram_arlen(s_cram_arlen),
        .s_cram_arsize(s_cram_arsize), .s_cram_arburst(s_cram_arburst),
        .s_cram_arvalid(s_cram_arvalid), .s_cram_arready(s_cram_arready),
        .s_cram_rid(s_cram_rid), .s_cram_rdata(s_cram_rdata), .s_cram_rresp(s_cram_rresp),
        .s_cram_rlast(s_cram_rlast), .s_cram_rvalid(s_cram_rvalid), .s_cram_rready(s_cram_rready),
        .outstanding(outstanding), .rid_err(rid_err)
    );

    typedef struct {
        logic        m0v;
        logic [31:0] a0;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        r0ready;
        logic        e_arvalid;
        logic [31:0] e_araddr;
        logic        e_m0ar;
        logic        e_m0rv;
        logic        e_rready;
        logic [2:0]  e_out;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        m0_arvalid = 0; m1_arvalid = 0; m0_araddr = 0; m1_araddr = 0;
        m0_rready = 0; m1_rready = 0;
        s_cram_arready = 0; s_cram_rid = 0; s_cram_rdata = 0; s_cram_rresp = 0;
        s_cram_rlast = 1; s_cram_rvalid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        set_idle();
        nrst = 1;
        tick();
        tick();
        nrst = 0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        set_idle();
        m0_arvalid = v.m0v; m0_araddr = v.a0; s_cram_arready = v.arready;
        s_cram_rvalid = v.rvalid; s_cram_rdata = v.rdata; m0_rready = v.r0ready;
        #1;
    endtask

    task automatic check_route(input string tag, input int dest);
        check_output({tag, " m0_rvalid"}, m0_rvalid, dest == 0);
        check_output({tag, " m1_rvalid"}, m1_rvalid, dest == 1);
    endtask

    vec_t vecs[5];
    int   exp_route[$];
    int   q[$];
    int   held, last_g, win, head, g;
    bit   model_err, hs0, hs1, rid_bit, e_arv, e_rr, do_pop;

    initial begin
        nrst = 1;
        set_idle();

        // Reset with requesters idle but CRAM ready high.
        s_cram_arready = 1;
        tick(); tick();
        nrst = 0;
        #1;
        check_output("reset s_arvalid", s_cram_arvalid, 0);
        check_output("reset m0_arready", m0_arready, 0);
        check_output("reset m1_arready", m1_arready, 0);
        check_output("reset m0_rvalid", m0_rvalid, 0);
        check_output("reset m1_rvalid", m1_rvalid, 0);
        check_output("reset s_rready", s_cram_rready, 0);
        check_output("reset outstanding", outstanding, 0);
        check_output("reset rid_err", rid_err, 0);
        check_output("arlen", s_cram_arlen, 0);
        check_output("arsize", s_cram_arsize, 2);
        check_output("arburst", s_cram_arburst, 1);

        // Fetch streaming table: m0 reads 0x0,0x4,0x8 with next-cycle data.
        vecs[0] = '{1, 32'h0, 1, 0, 32'h0,        0, 1, 32'h0, 1, 0, 0, 0};
        vecs[1] = '{1, 32'h4, 1, 1, 32'hA0A0_0000, 1, 1, 32'h4, 1, 1, 1, 1};
        vecs[2] = '{1, 32'h8, 1, 1, 32'hA0A0_0004, 1, 1, 32'h8, 1, 1, 1, 1};
        vecs[3] = '{0, 32'h0, 1, 1, 32'hA0A0_0008, 1, 0, 32'h0, 0, 1, 1, 1};
        vecs[4] = '{0, 32'h0, 0, 0, 32'h0,        0, 0, 32'h0, 0, 0, 0, 0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d s_arvalid", i), s_cram_arvalid, vecs[i].e_arvalid);
            if (vecs[i].e_arvalid) begin
                check_output($sformatf("vec%0d arid", i), s_cram_arid, 0);
                check_output($sformatf("vec%0d araddr", i), s_cram_araddr, vecs[i].e_araddr);
            end
            check_output($sformatf("vec%0d m0_arready", i), m0_arready, vecs[i].e_m0ar);
            check_output($sformatf("vec%0d m1_arready", i), m1_arready, 0);
            check_output($sformatf("vec%0d m0_rvalid", i), m0_rvalid, vecs[i].e_m0rv);
            check_output($sformatf("vec%0d m1_rvalid", i), m1_rvalid, 0);
            check_output($sformatf("vec%0d s_rready", i), s_cram_rready, vecs[i].e_rready);
            check_output($sformatf("vec%0d outstanding", i), outstanding, vecs[i].e_out);
            if (vecs[i].e_m0rv)
                check_output($sformatf("vec%0d m0_rdata", i), m0_rdata, vecs[i].rdata);
            tick();
        end

        // Contention until full, pop with simultaneous push, then drain.
        apply_reset();
        m0_arvalid = 1; m1_arvalid = 1; m0_araddr = 32'h40; m1_araddr = 32'h80;
        s_cram_arready = 1; m0_rready = 1; m1_rready = 1;
        for (int i = 0; i < 4; i++) begin
            g = RR ? (i % 2) : 0;
            #1;
            check_output($sformatf("cont%0d arid", i), s_cram_arid, g);
            check_output($sformatf("cont%0d araddr", i), s_cram_araddr, g ? 32'h80 : 32'h40);
            check_output($sformatf("cont%0d m0_arready", i), m0_arready, g == 0);
            check_output($sformatf("cont%0d m1_arready", i), m1_arready, g == 1);
            exp_route.push_back(g);
            tick();
        end
        s_cram_rvalid = 1; s_cram_rid = 4'(exp_route[0]); s_cram_rdata = 32'h1111;
        #1;
        check_output("full outstanding", outstanding, 4);
        check_output("full s_arvalid", s_cram_arvalid, 0);
        check_output("full m0_arready", m0_arready, 0);
        check_output("full m1_arready", m1_arready, 0);
        check_route("full pop", exp_route[0]);
        tick();
        void'(exp_route.pop_front());
        s_cram_rid = 4'(exp_route[0]);
        #1;
        check_output("after pop outstanding", outstanding, 3);
        check_output("push+pop m0_arready", m0_arready, 1);
        check_output("push+pop m1_arready", m1_arready, 0);
        check_route("push+pop", exp_route[0]);
        tick();
        void'(exp_route.pop_front());
        exp_route.push_back(0);
        m0_arvalid = 0; m1_arvalid = 0;
        for (int i = 0; i < 3; i++) begin
            s_cram_rid = 4'(exp_route[0]);
            #1;
            check_output($sformatf("drain%0d outstanding", i), outstanding, 3 - i);
            check_route($sformatf("drain%0d", i), exp_route[0]);
            tick();
            void'(exp_route.pop_front());
        end
        s_cram_rvalid = 0;
        #1;
        check_output("drained outstanding", outstanding, 0);
        check_output("drained rid_err", rid_err, 0);

        // Grant lock under AR backpressure.
        apply_reset();
        m1_arvalid = 1; m1_araddr = 32'h100;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                m0_arvalid = 1; m0_araddr = 32'h200;
            end
            #1;
            check_output($sformatf("lock%0d arid", i), s_cram_arid, 1);
            check_output($sformatf("lock%0d araddr", i), s_cram_araddr, 32'h100);
            tick();
        end
        s_cram_arready = 1;
        #1;
        check_output("lock hs arid", s_cram_arid, 1);
        check_output("lock hs m1_arready", m1_arready, 1);
        check_output("lock hs m0_arready", m0_arready, 0);
        tick();
        m1_arvalid = 0;
        #1;
        check_output("unlock arid", s_cram_arid, 0);
        check_output("unlock araddr", s_cram_araddr, 32'h200);
        check_output("unlock m0_arready", m0_arready, 1);
        tick();
        m0_arvalid = 0;

        // Stray beat stalls; mismatched rid sets sticky error.
        apply_reset();
        s_cram_rvalid = 1; s_cram_rid = 0; m0_rready = 1; m1_rready = 1;
        #1;
        check_output("stray s_rready", s_cram_rready, 0);
        check_route("stray", -1);
        tick();
        check_output("stray outstanding", outstanding, 0);
        s_cram_rvalid = 0; m0_arvalid = 1; m0_araddr = 32'hC; s_cram_arready = 1;
        tick();
        m0_arvalid = 0; s_cram_rvalid = 1; s_cram_rid = 1; s_cram_rdata = 32'hBEEF;
        #1;
        check_route("bad rid", 0);
        check_output("bad rid s_rready", s_cram_rready, 1);
        check_output("bad rid m0_rdata", m0_rdata, 32'hBEEF);
        tick();
        s_cram_rvalid = 0;
        tick(); tick();
        check_output("rid_err sticky", rid_err, 1);
        check_output("err outstanding", outstanding, 0);
        apply_reset();
        #1;
        check_output("rid_err cleared", rid_err, 0);

        // Random run against a queue-based model of the routing rules.
        apply_reset();
        q.delete();
        held = -1; last_g = 1; model_err = 0; hs0 = 0; hs1 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!m0_arvalid || hs0) begin
                m0_arvalid = ($urandom_range(0, 99) < 55);
                m0_araddr = $urandom & 32'h0000_FFFC;
            end
            if (!m1_arvalid || hs1) begin
                m1_arvalid = ($urandom_range(0, 99) < 45);
                m1_araddr = $urandom & 32'h0000_FFFC;
            end
            s_cram_arready = ($urandom_range(0, 99) < 65);
            head = (q.size() > 0) ? q[0] : -1;
            s_cram_rvalid = (head >= 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 10);
            rid_bit = (head >= 0) ? (head[0] ^ ($urandom_range(0, 31) == 0)) : 1'($urandom);
            s_cram_rid = {3'b000, rid_bit};
            s_cram_rlast = ($urandom_range(0, 31) != 0);
            s_cram_rdata = $urandom;
            s_cram_rresp = 2'($urandom);
            m0_rready = ($urandom_range(0, 99) < 75);
            m1_rready = ($urandom_range(0, 99) < 75);
            #1;

            if (held >= 0) win = held;
            else if (m0_arvalid && m1_arvalid) win = RR ? 1 - last_g : 0;
            else if (m0_arvalid) win = 0;
            else if (m1_arvalid) win = 1;
            else win = -1;
            e_arv = (m0_arvalid || m1_arvalid) && (q.size() < 4);
            e_rr = (head == 0) ? m0_rready : (head == 1) ? m1_rready : 1'b0;

            check_output("rnd s_arvalid", s_cram_arvalid, e_arv);
            check_output("rnd m0_arready", m0_arready, s_cram_arready && e_arv && win == 0);
            check_output("rnd m1_arready", m1_arready, s_cram_arready && e_arv && win == 1);
            if (e_arv) begin
                check_output("rnd arid", s_cram_arid, 4'(win));
                check_output("rnd araddr", s_cram_araddr, (win == 1) ? m1_araddr : m0_araddr);
            end
            check_route("rnd", s_cram_rvalid ? head : -1);
            check_output("rnd s_rready", s_cram_rready, e_rr);
            check_output("rnd outstanding", outstanding, q.size());
            check_output("rnd rid_err", rid_err, model_err);
            check_output("rnd m1_rresp", m1_rresp, s_cram_rresp);

            do_pop = (head >= 0) && s_cram_rvalid && e_rr;
            if (do_pop) begin
                if (rid_bit != head[0] || !s_cram_rlast) model_err = 1;
                void'(q.pop_front());
            end
            hs0 = 0; hs1 = 0;
            if (e_arv && s_cram_arready) begin
                q.push_back(win);
                last_g = win;
                held = -1;
                hs0 = (win == 0); hs1 = (win == 1);
            end else if (e_arv) begin
                held = win;
            end else begin
                held = -1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
